pattern_player: RTL and testbench

- Tick consumer on the far side of the game's clock divider: takes the divider's one-cycle blink tick and plays the stored memorization sequence on the LEDs.
- Reads one symbol per step from the sequence memory (synchronous read), lights the matching LED for ON_TICKS ticks, then blanks it for OFF_TICKS ticks.
- Signals completion to the game controller so the player-input phase can start.

---
 rtl/pattern_player_pkg.sv | 20 ++
 rtl/pattern_player_tick_counter.sv | 29 ++
 rtl/pattern_player.sv | 126 ++++++++++++
 tb/tb_pattern_player.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_player_pkg.sv
// Shared definitions for the memorization-game pattern player.
package pattern_player_pkg;

    localparam int unsigned NUM_LEDS      = 4;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned SEQ_MAX       = 16;
    localparam int unsigned LEN_W         = 5;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DEF_ON_TICKS  = 2;
    localparam int unsigned DEF_OFF_TICKS = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ON,
        OFF,
        DONE
    } state_t;

endpackage

// File: rtl/pattern_player_tick_counter.sv
// Counts blink ticks while enabled; flags the tick that reaches the target count.
module pattern_player_tick_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    // clear wins over a coincident tick, so that tick is not carried into the next phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && tick) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = en && tick && (count == target - CNT_W'(1));

endmodule

// File: rtl/pattern_player.sv
// Plays the stored sequence on the LEDs, one symbol per step, paced by the divider's blink tick.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blink_tick,
    input  logic                start,
    input  logic                abort,
    input  logic [LEN_W-1:0]    seq_len,
    output logic [LEN_W-2:0]    rd_addr,
    input  logic [IDX_W-1:0]    rd_data,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done
);

    state_t              state;
    state_t              next_state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    len_clamped;
    logic [IDX_W-1:0]    cur;
    logic                last;
    logic                tc_clear;
    logic                tc_en;
    logic                tc_hit;
    logic [CNT_W-1:0]    tc_target;
    logic [NUM_LEDS-1:0] led_d;
    logic                busy_d;
    logic                done_d;

    assign len_clamped = (seq_len > LEN_W'(SEQ_MAX)) ? LEN_W'(SEQ_MAX) : seq_len;
    assign last        = ({1'b0, rd_addr} == len - LEN_W'(1));

    assign tc_en     = (state == ON) || (state == OFF);
    assign tc_clear  = (next_state != state);
    assign tc_target = (state == ON) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);

    pattern_player_tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (tc_clear),
        .en    (tc_en),
        .tick  (blink_tick),
        .target(tc_target),
        .hit   (tc_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = (len_clamped == '0) ? DONE : FETCH;
                FETCH:   next_state = ON;
                ON:      if (tc_hit) next_state = OFF;
                OFF:     if (tc_hit) next_state = last ? DONE : FETCH;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len     <= '0;
            rd_addr <= '0;
            cur     <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                len     <= len_clamped;
                rd_addr <= '0;
            end
            if (state == FETCH) begin
                cur <= rd_data;
            end
            if (state == OFF && tc_hit && !abort && !last) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Outputs are decoded from the upcoming state and registered; on FETCH->ON the
    // symbol is taken straight from rd_data because cur is loaded on that same edge.
    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (next_state)
            FETCH, OFF: busy_d = 1'b1;
            ON: begin
                busy_d = 1'b1;
                led_d  = NUM_LEDS'(1) << ((state == FETCH) ? rd_data : cur);
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            led  <= led_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// Directed scenarios with randomized ticks and memory contents, checked against a span-level model.
module tb_pattern_player;
    import pattern_player_pkg::*;

    localparam int unsigned ON_T  = 2;
    localparam int unsigned OFF_T = 1;

    logic                clk        = 1'b0;
    logic                rst        = 1'b0;
    logic                blink_tick = 1'b0;
    logic                start      = 1'b0;
    logic                abort      = 1'b0;
    logic [LEN_W-1:0]    seq_len    = '0;
    logic [LEN_W-2:0]    rd_addr;
    logic [IDX_W-1:0]    rd_data;
    logic [NUM_LEDS-1:0] led;
    logic                busy;
    logic                done;

    logic [IDX_W-1:0]    mem [SEQ_MAX];

    int n_assert = 0;
    int n_fail   = 0;

    // tick source: mode 0 = one tick every 10 clk, mode 1 = random with tprob percent
    int tmode  = 0;
    int tphase = 0;
    int tprob  = 30;

    // playback model state
    bit                  in_play    = 1'b0;
    bit                  trk        = 1'b0;
    int                  exp_len    = 0;
    int                  flash_idx  = 0;
    int                  span_ticks = 0;
    int                  gap_ticks  = 0;
    int                  pending    = 0;
    int                  last_tick  = 0;
    int                  n_done     = 0;
    int                  addr_max   = 0;
    logic [NUM_LEDS-1:0] prev_led   = '0;

    pattern_player #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .blink_tick(blink_tick),
        .start     (start),
        .abort     (abort),
        .seq_len   (seq_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // synchronous-read memory, data settles within the cycle the address is presented
    always @(negedge clk) rd_data <= mem[rd_addr];

    function automatic logic [NUM_LEDS-1:0] sym_led(input logic [IDX_W-1:0] s);
        logic [NUM_LEDS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge: led/busy/done reflect this cycle, blink_tick is this cycle's tick.
    task automatic observe();
        check("led_onehot0", 32'($onehot0(led)), 1);
        if (done) begin
            check("busy_at_done", busy, 0);
            n_done++;
            if (trk) begin
                check("flash_count", flash_idx, exp_len);
                if (exp_len != 0) begin
                    check("final_gap_ticks", gap_ticks + pending, OFF_T);
                    check("final_gap_end_tick", pending, 1);
                end
            end
            in_play = 1'b0;
            trk     = 1'b0;
        end else begin
            check("busy", busy, in_play);
        end
        if (trk) begin
            if (int'(rd_addr) > addr_max) addr_max = int'(rd_addr);
            if (led != '0) begin
                if (prev_led == '0) begin
                    check("flash_in_range", flash_idx < exp_len, 1);
                    if (flash_idx < exp_len) check("flash_sym", led, sym_led(mem[flash_idx]));
                    if (flash_idx > 0) check("gap_ticks", gap_ticks, OFF_T);
                    span_ticks = 0;
                end else begin
                    check("led_stable", led, prev_led);
                end
                check("addr_during_flash", rd_addr, flash_idx);
                span_ticks += int'(blink_tick);
                last_tick   = int'(blink_tick);
            end else begin
                if (prev_led != '0) begin
                    check("lit_ticks", span_ticks, ON_T);
                    check("lit_end_tick", last_tick, 1);
                    flash_idx++;
                    gap_ticks = 0;
                    pending   = 0;
                end
                gap_ticks += pending;
                pending    = int'(blink_tick);
            end
        end
        prev_led = led;
    endtask

    task automatic cycle();
        if (tmode == 0) blink_tick = ((tphase % 10) == 9);
        else            blink_tick = ($urandom_range(0, 99) < tprob);
        tphase++;
        observe();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic begin_play(input int unsigned len);
        seq_len = LEN_W'(len);
        start   = 1'b1;
        cycle();
        start   = 1'b0;
        seq_len = LEN_W'($urandom);
        exp_len    = (len > SEQ_MAX) ? SEQ_MAX : len;
        in_play    = (exp_len != 0);
        trk        = 1'b1;
        flash_idx  = 0;
        n_done     = 0;
        gap_ticks  = 0;
        pending    = 0;
        span_ticks = 0;
        addr_max   = 0;
    endtask

    task automatic run_to_done(input int budget, input bit inject, input int inj_at);
        for (int c = 0; c < budget && n_done == 0; c++) begin
            if (inject && c == inj_at) begin
                start   = 1'b1;
                seq_len = LEN_W'($urandom_range(1, 31));
            end
            cycle();
            start = 1'b0;
        end
        check("done_seen", n_done, 1);
        repeat (4) cycle();
        check("single_done", n_done, 1);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < int'(SEQ_MAX); i++) mem[i] = IDX_W'($urandom);
    endtask

    initial begin
        fill_mem();
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;

        #2;
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rd_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();

        // three-symbol play, regular ticks
        tmode = 0; tphase = 0;
        begin_play(3);
        run_to_done(500, 1'b0, 0);

        // zero length finishes straight away
        n_done = 0;
        begin_play(0);
        check("len0_done", done, 1);
        check("len0_led", led, 0);
        check("len0_addr", rd_addr, 0);
        cycle();
        check("len0_done_fall", done, 0);
        check("len0_done_count", n_done, 1);
        repeat (3) cycle();

        // over-length request is clamped
        fill_mem();
        tmode = 0; tphase = 0;
        begin_play(20);
        run_to_done(1000, 1'b0, 0);
        check("clamp_addr_max", addr_max, SEQ_MAX - 1);

        // abort during the second lit step
        fill_mem();
        tmode = 1; tprob = 30;
        begin_play(4);
        for (int c = 0; c < 500 && !(flash_idx == 1 && led != '0); c++) cycle();
        check("abort_reach", (flash_idx == 1 && led != '0), 1);
        abort = 1'b1;
        cycle();
        abort   = 1'b0;
        in_play = 1'b0;
        trk     = 1'b0;
        n_done  = 0;
        check("abort_led", led, 0);
        check("abort_busy", busy, 0);
        repeat (20) cycle();
        check("abort_no_done", n_done, 0);
        begin_play(4);
        run_to_done(800, 1'b0, 0);

        // start together with abort in idle stays idle
        n_done = 0;
        start = 1'b1; abort = 1'b1; seq_len = 5'd3;
        cycle();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        repeat (5) cycle();
        check("idle_abort_no_done", n_done, 0);

        // dense ticks (coincident with step boundaries) plus a start mid-play
        tmode = 1; tprob = 50;
        for (int r = 0; r < 3; r++) begin
            fill_mem();
            begin_play(6);
            run_to_done(800, 1'b1, int'($urandom_range(5, 20)));
        end

        // asynchronous reset in the second dark gap
        fill_mem();
        tmode = 0; tphase = 0;
        begin_play(4);
        for (int c = 0; c < 500 && flash_idx != 2; c++) cycle();
        check("rst_midoff_reach", flash_idx, 2);
        check("rst_midoff_busy_before", busy, 1);
        #3 rst = 1'b0;
        #1;
        check("rst_midoff_led", led, 0);
        check("rst_midoff_busy", busy, 0);
        check("rst_midoff_done", done, 0);
        check("rst_midoff_addr", rd_addr, 0);
        in_play = 1'b0;
        trk     = 1'b0;
        n_done  = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        repeat (6) cycle();
        check("rst_no_done", n_done, 0);
        begin_play(3);
        run_to_done(500, 1'b0, 0);

        // random plays
        for (int r = 0; r < 4; r++) begin
            fill_mem();
            tmode = 1;
            tprob = int'($urandom_range(20, 60));
            begin_play($urandom_range(1, 20));
            run_to_done(3000, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
